pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB). It drives the load enables of the PC and the four pipeline registers, and it inserts bubbles and flushes, based on three conditions: cache wait, a load-use hazard, and a control redirect resolved in MEM. It also keeps saturating performance counters for stall and flush cycles. It sits beside the datapath and is the single owner of every stage-register load and flush signal.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer and stall/flush perf counters for the 5-stage LC-3b pipeline
module pipeline_hazard_ctrl #(
    parameter int CNT_W        = 16,
    parameter bit NOP_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      id_ir,
    input  logic [15:0]      ex_ir,
    input  logic             ex_valid,
    input  logic             mem_redirect,
    input  logic             icache_read,
    input  logic             icache_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic             perf_clear,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {S_RUN, S_BUBBLE, S_MEMWAIT} state_t;

    state_t     state;
    logic [3:0] id_op;
    logic [3:0] ex_op;
    logic [2:0] ex_dr;
    logic       ex_is_load;
    logic       reads_sr1;
    logic       reads_sr2;
    logic       reads_dr;
    logic       load_use;
    logic       mem_wait;
    logic       do_redirect;
    logic       do_bubble;

    assign id_op = id_ir[15:12];
    assign ex_op = ex_ir[15:12];
    assign ex_dr = ex_ir[11:9];

    always_comb begin
        ex_is_load = (ex_op == 4'b0110) || (ex_op == 4'b1010) || (ex_op == 4'b0010);
        reads_sr1  = 1'b0;
        reads_sr2  = 1'b0;
        reads_dr   = 1'b0;
        case (id_op)
            4'b0001, 4'b0101: begin
                reads_sr1 = 1'b1;
                reads_sr2 = ~id_ir[5];
            end
            4'b1001, 4'b1101, 4'b0110, 4'b0010, 4'b1010, 4'b1100: reads_sr1 = 1'b1;
            4'b0111, 4'b0011, 4'b1011: begin
                reads_sr1 = 1'b1;
                reads_dr  = 1'b1;
            end
            4'b0100: reads_sr1 = ~id_ir[11];
            default: ;
        endcase
        load_use = ex_valid && ex_is_load &&
                   ((reads_sr1 && (id_ir[8:6]  == ex_dr)) ||
                    (reads_sr2 && (id_ir[2:0]  == ex_dr)) ||
                    (reads_dr  && (id_ir[11:9] == ex_dr)));
    end

    assign mem_wait    = (icache_read & ~icache_resp) | (dmem_req & ~dmem_resp);
    assign do_redirect = mem_redirect & ~mem_wait;
    // A hazard seen while the bubble is already in flight must not bubble again.
    assign do_bubble   = load_use & ~mem_redirect & ~mem_wait & (state != S_BUBBLE);

    always_comb begin
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (!reset && !mem_wait) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            if (do_redirect) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
                if (!NOP_ON_FLUSH) begin
                    load_if_id  = 1'b0;
                    load_id_ex  = 1'b0;
                    load_ex_mem = 1'b0;
                end
            end else if (do_bubble) begin
                load_pc      = 1'b0;
                load_if_id   = 1'b0;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_RUN;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (mem_wait)
                state <= S_MEMWAIT;
            else if (do_bubble)
                state <= S_BUBBLE;
            else
                state <= S_RUN;

            if (perf_clear)
                stall_cycles <= '0;
            else if ((mem_wait || do_bubble) && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);

            if (perf_clear)
                flush_events <= '0;
            else if (do_redirect && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule
